// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================
// Package : i2c_pkg
// Purpose : shared state encodings and bus constants for the I2C read path
// Rev     : 1.0
// ============================================================
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_ACK = 3'd1,
        FETCH    = 3'd2,
        SHIFT    = 3'd3,
        MACK     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [7:0] ReadMask  = 8'h00;
    localparam logic [7:0] WriteMask = 8'h20;
    localparam logic       ACK       = 1'b0;
    localparam logic       NACK      = 1'b1;

    // Index width for a table of n entries; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_read_scheduler_if.sv
`default_nettype none
// ============================================================
// Interface : i2c_read_scheduler_if
// Purpose   : decoder, responder and transmitter signals of the read scheduler
// Rev       : 1.0
// ============================================================
interface i2c_read_scheduler_if #(
    parameter int NUM_PERIPH = 2
);
    logic                    cmd_valid;
    logic [6:0]              cmd_addr;
    logic                    cmd_rw;
    logic                    stop_det;
    logic                    sda_in;
    logic [NUM_PERIPH-1:0]   periph_req;
    logic [NUM_PERIPH-1:0]   periph_ack;
    logic [8*NUM_PERIPH-1:0] periph_data;
    logic                    tx_load;
    logic [7:0]              tx_byte;
    logic                    tx_enable;
    logic                    out_sel;
    logic                    ack_bit;
    logic [7:0]              direction;
    logic                    busy;
    logic [3:0]              byte_count;
    logic [7:0]              err_count;

    modport master (
        input  cmd_valid, cmd_addr, cmd_rw, stop_det, sda_in, periph_ack, periph_data,
        output periph_req, tx_load, tx_byte, tx_enable, out_sel, ack_bit, direction,
               busy, byte_count, err_count
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_rw, stop_det, sda_in, periph_ack, periph_data,
        input  periph_req, tx_load, tx_byte, tx_enable, out_sel, ack_bit, direction,
               busy, byte_count, err_count
    );
endinterface
`default_nettype wire

// File: rtl/i2c_addr_match.sv
`default_nettype none
// ============================================================
// Module  : i2c_addr_match
// Purpose : combinational address table lookup; lowest matching slot wins
// Rev     : 1.0
// ============================================================
module i2c_addr_match #(
    parameter int                      NUM_PERIPH = 2,
    parameter logic [7*NUM_PERIPH-1:0] ADDR_TABLE = {7'h55, 7'h2A},
    parameter int                      IW         = 1
) (
    input  wire logic [6:0]    addr,
    output logic               hit,
    output logic [IW-1:0]      idx
);

    // Scanning from the top down lets the lowest matching slot overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
            if (ADDR_TABLE[7*i +: 7] == addr) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_read_scheduler.sv
`default_nettype none
// ============================================================
// Module  : i2c_read_scheduler
// Purpose : sequences address ACK, byte fetch, shift-out and master ACK
//           for I2C reads. Option macro: I2C_SCHED_ERRCNT_EN (error counter).
// Rev     : 1.0
// ============================================================
module i2c_read_scheduler
    import i2c_pkg::*;
#(
    parameter int                      NUM_PERIPH    = 2,
    parameter logic [7*NUM_PERIPH-1:0] ADDR_TABLE    = {7'h55, 7'h2A},
    parameter logic [7:0]              BAD_BYTE      = 8'hCC,
    parameter int                      MAX_BYTES     = 8,
    parameter int                      FETCH_TIMEOUT = 15
) (
    input wire logic              clk,
    input wire logic              rst_n,
    i2c_read_scheduler_if.master  bus
);

    localparam int            IW         = idx_width(NUM_PERIPH);
    localparam int            TW         = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(FETCH_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [3:0]      byte_count_q, byte_count_d;
    logic            hit_q, hit_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            match_hit;
    logic [IW-1:0]   match_idx;
    logic            sel_ack;
    logic [7:0]      sel_data;
    logic [3:0]      next_count;

    logic [NUM_PERIPH-1:0] req;
    logic            load, enable, osel, abit;
    logic [7:0]      dir;

    i2c_addr_match #(
        .NUM_PERIPH (NUM_PERIPH),
        .ADDR_TABLE (ADDR_TABLE),
        .IW         (IW)
    ) u_addr_match (
        .addr (bus.cmd_addr),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    assign sel_ack    = bus.periph_ack[idx_q];
    assign sel_data   = bus.periph_data[{idx_q, 3'b000} +: 8];
    assign next_count = byte_count_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        byte_count_d = byte_count_q;
        hit_d        = hit_q;
        idx_d        = idx_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_rw) begin
                    hit_d        = match_hit;
                    idx_d        = match_idx;
                    byte_count_d = '0;
                    state_d      = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (hit_q) begin
                    state_d = FETCH;
                end else begin
                    tx_byte_d = BAD_BYTE;
                    state_d   = SHIFT;
                end
            end
            FETCH: begin
                bit_cnt_d = '0;
                if (sel_ack) begin
                    tx_byte_d = sel_data;
                    state_d   = SHIFT;
                end else if (timer_q == TIMER_LAST) begin
                    tx_byte_d = BAD_BYTE;
                    state_d   = SHIFT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = MACK;
                end
            end
            MACK: begin
                if (bus.sda_in == ACK) begin
                    byte_count_d = next_count;
                    if (next_count < 4'(MAX_BYTES)) begin
                        // An unmatched address keeps re-sending the BAD_BYTE already held.
                        if (hit_q) begin
                            timer_d = '0;
                            state_d = FETCH;
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = SHIFT;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.stop_det && (state_q != IDLE)) begin
            state_d   = IDLE;
            tx_byte_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_byte_q    <= '0;
            byte_count_q <= '0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            byte_count_q <= byte_count_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        req    = '0;
        load   = 1'b0;
        enable = 1'b0;
        osel   = 1'b1;
        abit   = NACK;
        dir    = ReadMask;
        case (state_q)
            ADDR_ACK: begin
                osel = 1'b0;
                abit = ACK;
                dir  = WriteMask;
            end
            FETCH: req[idx_q] = 1'b1;
            SHIFT: begin
                dir    = WriteMask;
                enable = 1'b1;
                load   = (bit_cnt_q == 3'd0);
            end
            default: ;
        endcase
    end

    assign bus.periph_req = req;
    assign bus.tx_load    = load;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_enable  = enable;
    assign bus.out_sel    = osel;
    assign bus.ack_bit    = abit;
    assign bus.direction  = dir;
    assign bus.busy       = (state_q != IDLE);
    assign bus.byte_count = byte_count_q;

`ifdef I2C_SCHED_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;
    logic       err_inc;

    always_comb begin
        err_inc = !bus.stop_det &&
                  (((state_q == ADDR_ACK) && !hit_q) ||
                   ((state_q == FETCH) && !sel_ack && (timer_q == TIMER_LAST)));
        err_count_d = err_count_q;
        if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = 8'h00;
`endif

endmodule
`default_nettype wire
